// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: the master issues start with
// two operands, the slave returns status, the sum, the carry and a done strobe.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] augend;
    logic [WIDTH-1:0] addend;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] sum;
    logic             outcarry;
    logic             done;

    modport master (
        output start, augend, addend,
        input  ready, busy, sum, outcarry, done
    );

    modport slave (
        input  start, augend, addend,
        output ready, busy, sum, outcarry, done
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder bit per clock, LSB first, with a fixed
// WIDTH-cycle RUN phase followed by a single-cycle DONE strobe.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_outcarry;
    logic [CW-1:0]    r_count;

    logic w_s;
    logic w_cNext;
    logic w_last;

    assign w_s     = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cNext = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_last  = (r_count == CW'(WIDTH - 1));

    // Status outputs decode straight from state so reset clears them at once.
    assign bus.ready    = (r_state == S_IDLE);
    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.sum      = r_sum;
    assign bus.outcarry = r_outcarry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_outcarry <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.augend;
                        r_b     <= bus.addend;
                        r_carry <= 1'b0;
                        r_count <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cNext;
                    r_count <= r_count + CW'(1);
                    // Carry out is only published once the MSB has been summed.
                    if (w_last) begin
                        r_outcarry <= w_cNext;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits; legal values are 2 to 32.

Interface
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk SHALL be an input, 1 bit, the rising-edge clock.
REQ-004 Port rst_n SHALL be an input, 1 bit, the asynchronous active-low reset.
REQ-005 Port start SHALL be an input, 1 bit, the request to begin an addition; it is sampled only in IDLE.
REQ-006 Port augend SHALL be an input, WIDTH bits, the first operand; it is captured on the accepting edge.
REQ-007 Port addend SHALL be an input, WIDTH bits, the second operand; it is captured on the accepting edge.
REQ-008 Port ready SHALL be an output, 1 bit, high only in IDLE.
REQ-009 Port busy SHALL be an output, 1 bit, high only in RUN.
REQ-010 Port sum SHALL be an output, WIDTH bits, the result (augend + addend) mod 2^WIDTH.
REQ-011 Port outcarry SHALL be an output, 1 bit, the carry out of the MSB.
REQ-012 Port done SHALL be an output, 1 bit, a single-cycle result-valid strobe.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-014 IDLE -> RUN SHALL occur on a rising edge where start=1. That edge is the accept edge E0, at which the block loads augend and addend into right-shift registers, clears the internal carry to 0 and clears the bit counter to 0.
REQ-015 Each rising edge in RUN SHALL process one bit, LSB first:
 - s = a0 ^ b0 ^ c
 - c_next = (a0 & b0) | (c & (a0 ^ b0))
 - shift s into the MSB of the sum register
 - shift both operand registers right by one
 - increment the counter
REQ-016 RUN -> DONE SHALL occur on edge E_WIDTH, the edge that processes bit WIDTH-1.
 - At that edge, sum holds the full result and outcarry is loaded with c_next.
 - Before that edge, outcarry keeps its previous value.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-018 Latency SHALL be fixed: done is high in the cycle following edge E_WIDTH, i.e. after edge E0+WIDTH. The minimum accept-to-accept interval is WIDTH+2 cycles.
REQ-019 Intermediate sum values in RUN SHALL be observable but carry no meaning. sum and outcarry are only defined from DONE until the next accept edge; they hold their values in IDLE.
REQ-020 start SHALL be ignored in RUN and DONE; operand changes after E0 SHALL NOT affect the result.
REQ-021 If start is held high continuously, the block SHALL accept on every IDLE cycle, giving back-to-back operations every WIDTH+2 cycles.
REQ-022 Overflow SHALL be reported only through outcarry; sum wraps modulo 2^WIDTH.
REQ-023 The block SHALL reconstruct a minuend from the half subtractor's outputs: sum = diff + subtrahend, summed bitwise over WIDTH bits with borrows resolved.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during an operation.

Reset
REQ-025 On rst_n low, regardless of clk and at any point in an operation, the block SHALL immediately force:
 - state = IDLE
 - sum = 0, outcarry = 0, done = 0, busy = 0, ready = 1
 - internal carry, counter and operand registers = 0
REQ-026 A reset during RUN SHALL abort the operation without producing a done pulse.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Verification (WIDTH=8)
REQ-028 Stimulus augend=0x00, addend=0x00, start pulse -> done at cycle E0+9, sum=0x00, outcarry=0.
REQ-029 Stimulus 0x5A + 0x3C -> sum=0x96, outcarry=0; 0xFF + 0x01 -> sum=0x00, outcarry=1; 0xFF + 0xFF -> sum=0xFE, outcarry=1.
REQ-030 Pulse start during RUN with different operands -> request ignored, first result unchanged, exactly one done pulse.
REQ-031 Assert rst_n low at cycle E0+4 -> immediately ready=1, busy=0, sum=0, outcarry=0; no done pulse follows.
REQ-032 Hold start high for 30 cycles -> done pulses spaced exactly 10 cycles apart; ready=1 only on the accept cycles.
REQ-033 Random check of 1000 pairs -> {outcarry,sum} == augend + addend, compared by a scoreboard. Separately, diff = (m - s) mod 256 and subtrahend = s (for random m, s) -> sum == m.
